// File: rtl/spi_mem_responder.sv
// spi_mem_responder: oversampled SPI mode-0 memory target (READ 0x03 / WRITE 0x02, optional FAST READ 0x0B under SPI_MEM_FAST_READ_EN).
module spi_mem_responder #(
  parameter int MEM_DEPTH = 8192,
  parameter int ADDR_BITS = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic cmd_err,
  output logic busy
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_cs_s, r_sclk_s, r_mosi_s;
  logic r_sclk_d, r_armed, r_load, r_miso, r_oe, r_err;
  logic [5:0] r_cnt;
  logic [7:0] r_sh, r_out;
  logic [AW-1:0] r_ptr;
  logic [1:0] r_mode;
  logic [7:0] r_mem [MEM_DEPTH];
  logic w_csn, w_rise, w_fall, w_mosi, w_last8, w_cmd_ok;
  logic [7:0] w_byte;
  assign w_csn   = r_cs_s[1];
  assign w_mosi  = r_mosi_s[1];
  assign w_rise  = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall  = ~r_sclk_s[1] & r_sclk_d;
  assign w_last8 = r_cnt == 6'd7;
  assign w_byte  = {r_sh[6:0], w_mosi};
`ifdef SPI_MEM_FAST_READ_EN
  assign w_cmd_ok = w_byte inside {8'h02, 8'h03, 8'h0B};
`else
  assign w_cmd_ok = w_byte inside {8'h02, 8'h03};
`endif
  // cs_n sync resets to "selected" so a transfer already under way at reset release cannot arm the block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_s   <= 2'b00;
      r_sclk_s <= 2'b00;
      r_mosi_s <= 2'b00;
      r_sclk_d <= 1'b0;
    end else begin
      r_cs_s   <= {r_cs_s[0], cs_n};
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_mosi_s <= {r_mosi_s[0], mosi};
      r_sclk_d <= r_sclk_s[1];
    end
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_csn && r_armed) w_next = S_CMD;
      S_CMD:   if (w_rise && w_last8) w_next = w_cmd_ok ? S_ADDR : S_IGNORE;
      S_ADDR:  if (w_rise && r_cnt == 6'(ADDR_BITS - 1))
                 w_next = r_mode == 2'd1 ? S_WDATA :
`ifdef SPI_MEM_FAST_READ_EN
                          r_mode == 2'd2 ? S_DUMMY :
`endif
                          S_RDATA;
`ifdef SPI_MEM_FAST_READ_EN
      S_DUMMY: if (w_rise && w_last8) w_next = S_RDATA;
`endif
      default: ;
    endcase
    if (r_state != S_IDLE && w_csn) w_next = S_IDLE;
  end
  always_comb begin
    busy    = r_state != S_IDLE;
    miso    = r_miso;
    miso_oe = r_oe;
    cmd_err = r_err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_oe    <= 1'b0;
      r_err   <= 1'b0;
      r_load  <= 1'b0;
      r_miso  <= 1'b0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_out   <= '0;
      r_ptr   <= '0;
      r_mode  <= '0;
    end else begin
      r_armed <= r_armed | w_csn;
      r_oe    <= ~w_csn;
      r_err   <= r_state == S_CMD && w_rise && w_last8 && !w_cmd_ok;
      r_load  <= w_next == S_RDATA && (r_state != S_RDATA || (w_fall && w_last8));
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == S_RDATA ? w_fall : w_rise) r_cnt <= (w_last8 && r_state != S_ADDR) ? 6'd0 : r_cnt + 6'd1;
      if (w_rise && (r_state == S_CMD || r_state == S_WDATA)) r_sh <= w_byte;
      if (w_rise && r_state == S_CMD && w_last8) r_mode <= w_byte == 8'h02 ? 2'd1 : w_byte == 8'h0B ? 2'd2 : 2'd0;
      if (w_rise && r_state == S_ADDR) r_ptr <= {r_ptr[AW-2:0], w_mosi};
      else if ((w_rise && r_state == S_WDATA && w_last8) || (w_fall && r_state == S_RDATA && w_last8)) r_ptr <= r_ptr + PTR_ONE;
      if (r_load) r_out <= r_mem[r_ptr];
      else if (w_fall && r_state == S_RDATA) r_out <= {r_out[6:0], 1'b0};
      r_miso <= r_state != S_RDATA ? 1'b0 : w_fall ? r_out[7] : r_miso;
    end
  end
  always_ff @(posedge clk) if (!rst && r_state == S_WDATA && w_rise && w_last8) r_mem[r_ptr] <= w_byte;
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: directed + randomized SPI transactions against a byte-array reference model.
module tb_spi_mem_responder;
  localparam int DEPTH = 8192;
  localparam int H = 50;
  logic clk = 1'b0, rst = 1'b1, cs_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic miso, miso_oe, cmd_err, busy;
  int n_pass = 0, n_total = 0, err_cnt = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] wbuf [16];
  logic [7:0] rbuf [16];

  spi_mem_responder #(.MEM_DEPTH(DEPTH), .ADDR_BITS(24)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (cmd_err === 1'b1) err_cnt++;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bit_x(input logic b, output logic r);
    mosi = b;
    #H sclk = 1'b1;
    r = miso;
    #H sclk = 1'b0;
  endtask

  task automatic byte_x(input logic [7:0] t, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_x(t[i], b);
      r[i] = b;
    end
  endtask

  task automatic sel();
    cs_n = 1'b0;
    #H;
  endtask

  task automatic desel();
    #H cs_n = 1'b1;
    #(2 * H);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] r;
    byte_x(cmd, r);
    byte_x(a[23:16], r);
    byte_x(a[15:8], r);
    byte_x(a[7:0], r);
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    logic [7:0] r;
    sel();
    hdr(8'h02, a);
    for (int i = 0; i < n; i++) begin
      byte_x(wbuf[i], r);
      model[(int'(a) + i) % DEPTH] = wbuf[i];
    end
    desel();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    sel();
    hdr(8'h03, a);
    for (int i = 0; i < n; i++) byte_x(8'h00, rbuf[i]);
    desel();
  endtask

  task automatic read_check(input string tag, input logic [23:0] a, input int n);
    do_read(a, n);
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 32'(rbuf[i]), 32'(model[(int'(a) + i) % DEPTH]));
  endtask

  initial begin
    logic [7:0] r, acc;
    logic [23:0] a;
    int n, e0;
    repeat (5) @(negedge clk);
    check("rst_miso", 32'(miso), 0);
    check("rst_oe", 32'(miso_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(cmd_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_oe", 32'(miso_oe), 0);

    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    do_write(24'h000010, 2);
    read_check("wr_rd", 24'h000010, 2);

    wbuf[0] = 8'h12; wbuf[1] = 8'h34;
    do_write(24'h001FFF, 2);
    read_check("wrap", 24'h001FFF, 2);
    read_check("wrap0", 24'h000000, 1);

    for (int k = 0; k < 6; k++) begin
      a = 24'($urandom);
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(a, n);
      read_check($sformatf("rnd%0d", k), a, n);
    end

    e0 = err_cnt;
    acc = 8'h00;
    sel();
    byte_x(8'hFF, r);
    for (int i = 0; i < 4; i++) begin
      byte_x(8'($urandom), r);
      acc |= r;
    end
    check("bad_oe", 32'(miso_oe), 1);
    desel();
    check("bad_err_pulses", 32'(err_cnt - e0), 1);
    check("bad_miso", 32'(acc), 0);
    read_check("bad_after", 24'h000000, 1);

    wbuf[0] = 8'($urandom);
    do_write(24'h000020, 1);
    sel();
    hdr(8'h02, 24'h000020);
    for (int i = 7; i >= 4; i--) bit_x(r[0] ^ 1'b1 ? 1'b1 : 1'b0, r[1]);
    #H cs_n = 1'b1;
    #40;
    check("partial_busy", 32'(busy), 0);
    #60;
    read_check("partial", 24'h000020, 1);

    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write(24'h000040, 2);
    sel();
    hdr(8'h03, 24'h000040);
    byte_x(8'h00, r);
    check("rstmid_b0", 32'(r), 32'(model[16'h40]));
    for (int i = 0; i < 4; i++) bit_x(1'b0, r[0]);
    rst = 1'b1;
    #10;
    check("rstmid_miso", 32'(miso), 0);
    check("rstmid_oe", 32'(miso_oe), 0);
    check("rstmid_busy", 32'(busy), 0);
    #30 rst = 1'b0;
    #H;
    e0 = err_cnt;
    hdr(8'h02, 24'h000040);
    byte_x(8'($urandom), r);
    byte_x(8'hFF, r);
    check("norestart_busy", 32'(busy), 0);
    check("norestart_err", 32'(err_cnt - e0), 0);
    desel();
    read_check("rstmid_after", 24'h000040, 2);

    e0 = err_cnt;
    sel();
    hdr(8'h0B, 24'h000010);
    byte_x(8'($urandom), r);
    byte_x(8'h00, r);
    desel();
`ifdef SPI_MEM_FAST_READ_EN
    check("fast_data", 32'(r), 32'(model[16'h10]));
    check("fast_err", 32'(err_cnt - e0), 0);
`else
    check("fast_data", 32'(r), 0);
    check("fast_err", 32'(err_cnt - e0), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

- Synthesizable SPI mode-0 memory responder: the target end of the shared SPI bus that the memory controller drives as an initiator (`flash_cs_n`/`ram_cs_n`, `spi_sclk`, `spi_mosi`, `spi_miso`).
- Holds a byte array and answers the 0x03 READ and 0x02 WRITE command set with 24-bit addresses.
- Runs entirely in the system clock domain by oversampling the SPI pins.
- Serves as the on-chip/FPGA stand-in for the external PSRAM, and as a bus-level checker in SoC benches.

## Interface
Parameters:
- `MEM_DEPTH`, default 8192: array size in bytes. Must be a power of two.
- `ADDR_BITS`, default 24: address bits shifted in per command.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `cs_n` in 1: chip select from initiator, active-low, asynchronous to `clk`.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `mosi` in 1: serial data in.
- `miso` out 1: serial data out.
- `miso_oe` out 1: high while selected; the bus mux uses it to route `miso`.
- `cmd_err` out 1: one-`clk` pulse on an unsupported command byte.
- `busy` out 1: high from synced `cs_n` fall to synced `cs_n` rise.

## Operation
Input synchronisation:
- `cs_n`, `sclk` and `mosi` each pass through 2-flop synchronisers.
- Rising and falling `sclk` edges are detected from the synced value and its delayed copy.
- `mosi` is sampled on a detected rising edge.
- `miso` is updated on a detected falling edge.

States:
- **IDLE**: waits for synced `cs_n` low, then clears the bit counter and enters CMD.
- **CMD**: shifts in 8 bits, MSB first. On the 8th bit:
  - 0x03 → ADDR(read)
  - 0x02 → ADDR(write)
  - 0x0B → ADDR(fast) when enabled
  - any other byte → pulse `cmd_err` and go to IGNORE.
- **ADDR**: shifts in `ADDR_BITS` bits, MSB first. The pointer is the low log2(`MEM_DEPTH`) bits; upper bits are ignored. The last address bit goes to RDATA (read), WDATA (write) or DUMMY (fast).
- **DUMMY**: counts 8 rising edges, then goes to RDATA.
- **RDATA**:
  - On entry, loads `mem[ptr]` into the output shifter.
  - Each falling edge presents the next bit, MSB first. The first bit appears on the falling edge after the last address/dummy bit.
  - After 8 bits the pointer increments and the next byte is loaded, so sequential read is unbounded.
- **WDATA**:
  - Shifts in 8 bits.
  - On the 8th rising edge, writes `mem[ptr]` and increments the pointer.
- **IGNORE**: `miso` held 0 until deselect.

Pointer rules:
- The pointer wraps from `MEM_DEPTH-1` to 0 on both read and write.

Deselect and reset:
- Synced `cs_n` high in any state → IDLE next cycle.
- A partial write byte is discarded; a partial read is abandoned.
- Reset affects control state only; the memory array is not cleared.
- Reset values: `miso`=0, `miso_oe`=0, `cmd_err`=0, `busy`=0, state IDLE, counters 0.
- `rst` asserted mid-transfer aborts the transfer.
- After `rst` is released while `cs_n` is still low, the block does not start on that transfer. It stays in IDLE until `cs_n` has been seen high and then low again.

Output enables:
- `miso_oe` = synced `cs_n` low and not in reset.
- `miso` = 0 whenever not in RDATA.

## Timing
- Edge detection latency: pin edge → internal action is 3 `clk` cycles (2 sync + 1 detect).
- `miso` changes 3–4 `clk` after the `sclk` falling edge.
- Requirement: `sclk` high and low phases each ≥ 4 `clk`. This gives `sclk` ≤ `clk`/8 and guarantees `miso` settles before the initiator's next rising edge.
- `cs_n` setup to first `sclk` rise ≥ 4 `clk`.
- `cs_n` high time between transfers ≥ 4 `clk`.
- A write byte is visible to a subsequent read 1 `clk` after the 8th detected rising edge.
- `cmd_err` fires 1 `clk` after the 8th command-bit sample.

## Configuration
- `SPI_MEM_FAST_READ_EN`:
  - Defined: 0x0B FAST READ is accepted, with 8 dummy clocks between the address and data phases.
  - Undefined: the DUMMY state is not built, and 0x0B is treated as an unsupported command (`cmd_err` pulse, IGNORE).

## Test plan
- Write then read: 0x02, addr 0x000010, data 0xAA 0x55, deselect; then 0x03, addr 0x000010, 16 clocks → `miso` returns 0xAA 0x55.
- Read wrap: preload `mem[0x1FFF]`=0x12 and `mem[0]`=0x34; 0x03 at addr 0x001FFF, 16 clocks → 0x12 0x34.
- Unsupported command: 0xFF → one `cmd_err` pulse; `miso`=0 for 32 further clocks; a following read of addr 0 shows the array unchanged.
- Partial write: 0x02, addr 0x000020, data 0xC3, deselect after 4 data bits → `mem[0x20]` keeps its prior value; `busy` drops within 4 `clk` of `cs_n` rise.
- Reset mid-read: assert `rst` during the 2nd data byte → next cycle `miso`=0, `miso_oe`=0, `busy`=0; a following full read returns the original data.
- Fast read (macro defined): 0x0B, addr 0x000010, 8 dummy clocks, 8 clocks → 0xAA. Macro undefined: same sequence → `cmd_err` pulse, `miso`=0.
